// File: rtl/k005297_byte_assembler_pkg.sv
// Shared k005297 definitions: byte geometry, strobe widths and transfer modes.
package k005297_byte_assembler_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BITCNT_W   = $clog2(BYTE_W);
    localparam int unsigned BITS_1LINE = 1;
    localparam int unsigned BITS_2LINE = 2;

    typedef enum logic {
        MODE_1LINE = 1'b0,
        MODE_2LINE = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } state_e;

    // i_4BEN_n low selects the 2-line (4BEN) transfer
    function automatic mode_e mode_from_4ben(input logic four_ben_n);
        return four_ben_n ? MODE_1LINE : MODE_2LINE;
    endfunction

    // Carry-width step so the caller can see the byte-full overflow
    function automatic logic [BITCNT_W:0] bits_per_strobe(input mode_e mode);
        return (mode == MODE_2LINE) ? (BITCNT_W+1)'(BITS_2LINE)
                                    : (BITCNT_W+1)'(BITS_1LINE);
    endfunction

endpackage

// File: rtl/k005297_byte_assembler_if.sv
// Byte hand-off between the assembler and the buffer-write logic.
interface k005297_byte_assembler_if;
    import k005297_byte_assembler_pkg::*;

    logic [BYTE_W-1:0] BYTE;
    logic              BYTE_VALID;
    logic              BYTE_ACK;

    modport master (output BYTE, output BYTE_VALID, input BYTE_ACK);
    modport slave  (input BYTE, input BYTE_VALID, output BYTE_ACK);

endinterface

// File: rtl/k005297_byte_assembler_shreg.sv
// Bit-insert shift register and bit counter; exposes the byte as it would look after this strobe.
module k005297_byte_assembler_shreg
    import k005297_byte_assembler_pkg::*;
(
    input  logic                i_MCLK,
    input  logic                i_RST,
    input  logic                en,
    input  logic                clr,
    input  logic                stb,
    input  mode_e               mode,
    input  logic [1:0]          data,
    output logic [BYTE_W-1:0]   full_byte_c,
    output logic                complete_c,
    output logic [BITCNT_W-1:0] bitcnt
);

    logic [BYTE_W-1:0] shreg_q;
    logic [BITCNT_W:0] sum_c;

    // Second line lands at bitcnt+1 modulo the byte, so an odd count still stays in range
    always_comb begin
        full_byte_c         = shreg_q;
        full_byte_c[bitcnt] = data[0];
        if (mode == MODE_2LINE) begin
            full_byte_c[BITCNT_W'(bitcnt + BITCNT_W'(1))] = data[1];
        end
        sum_c      = {1'b0, bitcnt} + bits_per_strobe(mode);
        complete_c = stb && sum_c[BITCNT_W];
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            shreg_q <= '0;
            bitcnt  <= '0;
        end else if (en) begin
            if (clr) begin
                shreg_q <= '0;
                bitcnt  <= '0;
            end else if (stb) begin
                shreg_q <= full_byte_c;
                bitcnt  <= sum_c[BITCNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/k005297_byte_assembler.sv
// Bubble read-data byte assembler: deserialises strobed bits, hands bytes downstream, flags overruns.
module k005297_byte_assembler
    import k005297_byte_assembler_pkg::*;
#(
    parameter bit OVR_STICKY = 1'b1
)(
    input  logic                       i_MCLK,
    input  logic                       i_RST,
    input  logic                       i_CLK2M_PCEN_n,
    input  logic                       i_ACC_ACT_n,
    input  logic                       i_4BEN_n,
    input  logic                       i_BITSTB,
    input  logic [1:0]                 i_BUBDATA,
    k005297_byte_assembler_if.master   bus,
    output logic                       o_GLCNT_RD,
    output logic                       o_NEWBYTE,
    output logic                       o_OVERRUN,
    output logic [BITCNT_W-1:0]        o_BITCNT
);

    state_e            state_q;
    logic [BYTE_W-1:0] byte_q;
    logic              valid_q;

    logic              en_c;
    logic              abort_c;
    logic              accept_c;
    mode_e             mode_c;
    logic [BYTE_W-1:0] full_byte_c;
    logic              complete_c;
    logic              ack_take_c;
    logic              load_c;

    always_comb begin
        en_c       = !i_CLK2M_PCEN_n;
        abort_c    = i_ACC_ACT_n;
        accept_c   = !i_ACC_ACT_n && i_BITSTB;
        mode_c     = mode_from_4ben(i_4BEN_n);
        ack_take_c = bus.BYTE_ACK && valid_q && (state_q == ST_ASSEMBLE);
        // A completing byte may replace the held one only if it is free or being taken now
        load_c     = complete_c && (!valid_q || bus.BYTE_ACK);
    end

    k005297_byte_assembler_shreg u_shreg (
        .i_MCLK      (i_MCLK),
        .i_RST       (i_RST),
        .en          (en_c),
        .clr         (abort_c),
        .stb         (accept_c),
        .mode        (mode_c),
        .data        (i_BUBDATA),
        .full_byte_c (full_byte_c),
        .complete_c  (complete_c),
        .bitcnt      (o_BITCNT)
    );

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            o_GLCNT_RD <= 1'b0;
            o_NEWBYTE  <= 1'b0;
            o_OVERRUN  <= 1'b0;
        end else if (en_c) begin
            o_GLCNT_RD <= 1'b0;
            o_NEWBYTE  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ASSEMBLE: begin
                    if (abort_c) begin
                        state_q   <= ST_IDLE;
                        valid_q   <= 1'b0;
                        o_OVERRUN <= 1'b0;
                    end else begin
                        state_q    <= ST_ASSEMBLE;
                        o_GLCNT_RD <= accept_c;
                        o_NEWBYTE  <= complete_c;
                        if (load_c) begin
                            byte_q  <= full_byte_c;
                            valid_q <= 1'b1;
                        end else if (complete_c) begin
                            o_OVERRUN <= 1'b1;
                        end else if (ack_take_c) begin
                            valid_q <= 1'b0;
                        end
                        if (ack_take_c && !OVR_STICKY) begin
                            o_OVERRUN <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.BYTE       = byte_q;
    assign bus.BYTE_VALID = valid_q;

endmodule

// File: tb/tb_k005297_byte_assembler.sv
// Scoreboard bench for k005297_byte_assembler: directed scenarios plus random traffic against a bit-level model.
module tb_k005297_byte_assembler;
    import k005297_byte_assembler_pkg::*;

    localparam bit STICKY = 1'b1;

    typedef struct {
        logic [7:0] byt;
        logic       valid;
        logic       glc;
        logic       nb;
        logic       ovr;
        logic [2:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pcen_n = 1'b1;
    logic       acc_n = 1'b1;
    logic       fb = 1'b1;
    logic       stb = 1'b0;
    logic [1:0] d = 2'b00;
    logic       glc, nb, ovr;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    k005297_byte_assembler_if bus();

    k005297_byte_assembler #(.OVR_STICKY(STICKY)) dut (
        .i_MCLK         (clk),
        .i_RST          (rst),
        .i_CLK2M_PCEN_n (pcen_n),
        .i_ACC_ACT_n    (acc_n),
        .i_4BEN_n       (fb),
        .i_BITSTB       (stb),
        .i_BUBDATA      (d),
        .bus            (bus.master),
        .o_GLCNT_RD     (glc),
        .o_NEWBYTE      (nb),
        .o_OVERRUN      (ovr),
        .o_BITCNT       (cnt)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t cur;
    bit   upd = 1'b0;
    bit   armed = 1'b0;
    int   glc_seen = 0;
    int   nb_seen = 0;
    bit   cur_fb = 1'b1;

    logic [7:0] m_part = 8'h00;
    logic [7:0] m_byte = 8'h00;
    int         m_cnt = 0;
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: partial byte as an integer bit map filled LSB first; bytes leave when 8 bits are in
    function automatic exp_t model_step(input bit r, input bit a_n, input bit fbn, input bit s,
                                        input logic [1:0] dd, input bit ack);
        exp_t e;
        int   step;
        bit   full;
        bit   took;
        e.glc = 1'b0;
        e.nb  = 1'b0;
        if (r) begin
            m_part = 8'h00; m_cnt = 0; m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
        end else if (a_n) begin
            m_part = 8'h00; m_cnt = 0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            step = fbn ? 1 : 2;
            full = 1'b0;
            took = ack && m_valid;
            if (s) begin
                m_part[3'(m_cnt)] = dd[0];
                if (step == 2) m_part[3'((m_cnt + 1) % 8)] = dd[1];
                m_cnt = m_cnt + step;
                full  = (m_cnt >= 8);
                m_cnt = m_cnt % 8;
            end
            e.glc = s;
            e.nb  = full;
            if (full && (!m_valid || ack)) begin
                m_byte  = m_part;
                m_valid = 1'b1;
            end else if (full) begin
                m_ovr = 1'b1;
            end else if (took) begin
                m_valid = 1'b0;
            end
            if (took && !STICKY) m_ovr = 1'b0;
        end
        e.byt   = m_byte;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        e.cnt   = 3'(m_cnt);
        return e;
    endfunction

    task automatic cyc(input bit r, input bit pn, input bit a_n, input bit s,
                       input logic [1:0] dd, input bit ack);
        @(negedge clk);
        rst = r; pcen_n = pn; acc_n = a_n; fb = cur_fb; stb = s; d = dd; bus.BYTE_ACK = ack;
        if (r || !pn) q.push_back(model_step(r, a_n, cur_fb, s, dd, ack));
    endtask

    task automatic strobe(input logic [1:0] dd, input bit ack);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, dd, ack);
    endtask

    task automatic hold(input bit ack);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ack);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack_last);
        for (int i = 0; i < 8; i++) strobe({1'b0, b[i]}, (i == 7) ? ack_last : 1'b0);
    endtask

    // Monitor: every update edge retires one expectation; outputs are held between edges
    always @(posedge clk) upd <= rst || !pcen_n;

    always @(negedge clk) begin
        if (upd) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL queue_underflow: got 0 entries expected 1 at %0t", $time);
            end else begin
                cur   = q.pop_front();
                armed = 1'b1;
            end
            if (glc === 1'b1) glc_seen++;
            if (nb === 1'b1) nb_seen++;
        end
        if (armed) begin
            chk("o_BYTE", bus.BYTE, cur.byt);
            chk("o_BYTE_VALID", 8'(bus.BYTE_VALID), 8'(cur.valid));
            chk("o_GLCNT_RD", 8'(glc), 8'(cur.glc));
            chk("o_NEWBYTE", 8'(nb), 8'(cur.nb));
            chk("o_OVERRUN", 8'(ovr), 8'(cur.ovr));
            chk("o_BITCNT", 8'(cnt), 8'(cur.cnt));
        end
    end

    initial begin
        int g0;
        int n0;
        bus.BYTE_ACK = 1'b0;

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        idle();
        chk("reset_byte", bus.BYTE, 8'h00);
        chk("reset_valid", 8'(bus.BYTE_VALID), 8'h00);
        chk("reset_bitcnt", 8'(cnt), 8'h00);

        // 1-line: bits 1,0,1,1,0,0,1,0
        g0 = glc_seen; n0 = nb_seen;
        send_byte(8'h4D, 1'b0);
        idle();
        chk("line1_byte", bus.BYTE, 8'h4D);
        chk("line1_valid", 8'(bus.BYTE_VALID), 8'h01);
        chk("line1_glcnt_pulses", 8'(glc_seen - g0), 8'd8);
        chk("line1_newbyte_pulses", 8'(nb_seen - n0), 8'd1);
        hold(1'b1);
        idle();
        chk("ack_clears_valid", 8'(bus.BYTE_VALID), 8'h00);

        // 2-line
        cur_fb = 1'b0;
        strobe(2'b01, 1'b0); idle(); chk("line2_cnt2", 8'(cnt), 8'd2);
        strobe(2'b11, 1'b0); idle(); chk("line2_cnt4", 8'(cnt), 8'd4);
        strobe(2'b00, 1'b0); idle(); chk("line2_cnt6", 8'(cnt), 8'd6);
        strobe(2'b10, 1'b0); idle(); chk("line2_cnt0", 8'(cnt), 8'd0);
        chk("line2_byte", bus.BYTE, 8'h8D);
        hold(1'b1);
        cur_fb = 1'b1;

        // Overrun, sticky across ack
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        idle();
        chk("ovr_byte_kept", bus.BYTE, 8'hA5);
        chk("ovr_flag", 8'(ovr), 8'h01);
        hold(1'b1);
        idle();
        chk("ovr_sticky_after_ack", 8'(ovr), 8'(STICKY));

        // Ack on the completing edge
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        idle();
        chk("abort_clears_ovr", 8'(ovr), 8'h00);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        idle();
        chk("ack_same_edge_byte", bus.BYTE, 8'h3C);
        chk("ack_same_edge_valid", 8'(bus.BYTE_VALID), 8'h01);
        chk("ack_same_edge_ovr", 8'(ovr), 8'h00);

        // Abort mid-byte with a byte still pending
        for (int i = 0; i < 5; i++) strobe(2'b00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        idle();
        chk("abort_bitcnt", 8'(cnt), 8'h00);
        chk("abort_valid", 8'(bus.BYTE_VALID), 8'h00);
        chk("abort_keeps_byte", bus.BYTE, 8'h3C);
        send_byte(8'hFF, 1'b0);
        idle();
        chk("after_abort_byte", bus.BYTE, 8'hFF);

        // Reset while the enable is inactive, mid-byte with overrun set
        send_byte(8'h12, 1'b0);
        for (int i = 0; i < 3; i++) strobe(2'b01, 1'b0);
        idle();
        chk("pre_reset_ovr", 8'(ovr), 8'h01);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        idle();
        chk("rst_noen_byte", bus.BYTE, 8'h00);
        chk("rst_noen_valid", 8'(bus.BYTE_VALID), 8'h00);
        chk("rst_noen_ovr", 8'(ovr), 8'h00);
        chk("rst_noen_bitcnt", 8'(cnt), 8'h00);

        // Random traffic; mode only flips on a byte boundary
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit pn;
            bit an;
            r  = ($urandom_range(0, 299) == 0);
            pn = ($urandom_range(0, 3) == 0);
            an = ($urandom_range(0, 39) == 0);
            if (m_cnt == 0 && $urandom_range(0, 9) == 0) cur_fb = ~cur_fb;
            cyc(r, pn, an, 1'($urandom_range(0, 9) < 6), 2'($urandom), 1'($urandom_range(0, 9) < 3));
        end
        idle();
        idle();
        chk("queue_drained", 8'(q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
